// File: rtl/fetch_pkg.sv
// Shared types and instruction-field constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH,
    PREFETCH,
    BUFFERED,
    DRAIN
  } fetch_state_t;

  localparam int INSTR_WIDTH = 32;
  localparam int IMM26_MSB   = 25;
  localparam int IMM19_MSB   = 23;
  localparam int IMM19_LSB   = 5;

endpackage

// File: rtl/fetch_br_target.sv
// Branch target resolution: pc + (sign-extended imm26 or imm19) * 4, wrapping.
module fetch_br_target
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 64
) (
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic [IMM26_MSB:0]    opcode_i,
  input  logic                  uncond_i,
  output logic [ADDR_WIDTH-1:0] target_o
);

  localparam int IMM26_W = IMM26_MSB + 1;
  localparam int IMM19_W = IMM19_MSB - IMM19_LSB + 1;

  logic [ADDR_WIDTH-1:0] imm26_sext;
  logic [ADDR_WIDTH-1:0] imm19_sext;
  logic [ADDR_WIDTH-1:0] offset;

  assign imm26_sext = {{(ADDR_WIDTH-IMM26_W){opcode_i[IMM26_MSB]}}, opcode_i[IMM26_MSB:0]};
  assign imm19_sext = {{(ADDR_WIDTH-IMM19_W){opcode_i[IMM19_MSB]}}, opcode_i[IMM19_MSB:IMM19_LSB]};
  assign offset     = (uncond_i ? imm26_sext : imm19_sext) << 2;
  assign target_o   = pc_i + offset;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: single-request imem handshake, one prefetch slot, and
// discard of in-flight fetches after a taken branch.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] OPCode,
  output logic [ADDR_WIDTH-1:0]  pc_out,
  output logic                   instr_valid,
  input  logic                   id_ready,
  input  logic                   BrTaken,
  input  logic                   UncondBr
);

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  fetch_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0]  redirect_pc_q, redirect_pc_d;
  logic [ADDR_WIDTH-1:0]  pc_out_q, pc_out_d;
  logic [INSTR_WIDTH-1:0] opcode_q, opcode_d;
  logic [INSTR_WIDTH-1:0] pf_instr_q, pf_instr_d;
  logic [ADDR_WIDTH-1:0]  br_target;
  logic                   consume;

  fetch_br_target #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_br_target (
    .pc_i     (pc_out_q),
    .opcode_i (opcode_q[IMM26_MSB:0]),
    .uncond_i (UncondBr),
    .target_o (br_target)
  );

  assign instr_valid = (state_q == PREFETCH) || (state_q == BUFFERED);
  assign imem_req    = !reset && (state_q != BUFFERED);
  assign imem_addr   = fetch_pc_q;
  assign OPCode      = opcode_q;
  assign pc_out      = pc_out_q;
  assign consume     = instr_valid && id_ready;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    redirect_pc_d = redirect_pc_q;
    pc_out_d      = pc_out_q;
    opcode_d      = opcode_q;
    pf_instr_d    = pf_instr_q;
    case (state_q)
      FETCH: begin
        if (imem_ack) begin
          opcode_d   = imem_rdata;
          pc_out_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + PC_STEP;
          state_d    = PREFETCH;
        end
      end
      PREFETCH: begin
        if (consume && BrTaken) begin
          // A taken branch makes the prefetch stale; drain it if still in flight.
          if (imem_ack) begin
            fetch_pc_d = br_target;
            state_d    = FETCH;
          end else begin
            redirect_pc_d = br_target;
            state_d       = DRAIN;
          end
        end else if (consume) begin
          if (imem_ack) begin
            opcode_d   = imem_rdata;
            pc_out_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + PC_STEP;
          end else begin
            state_d = FETCH;
          end
        end else if (imem_ack) begin
          pf_instr_d = imem_rdata;
          fetch_pc_d = fetch_pc_q + PC_STEP;
          state_d    = BUFFERED;
        end
      end
      BUFFERED: begin
        if (consume && BrTaken) begin
          fetch_pc_d = br_target;
          state_d    = FETCH;
        end else if (consume) begin
          opcode_d = pf_instr_q;
          pc_out_d = pc_out_q + PC_STEP;
          state_d  = PREFETCH;
        end
      end
      DRAIN: begin
        if (imem_ack) begin
          fetch_pc_d = redirect_pc_q;
          state_d    = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FETCH;
      fetch_pc_q    <= RESET_PC;
      redirect_pc_q <= '0;
      pc_out_q      <= RESET_PC;
      opcode_q      <= '0;
      pf_instr_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      redirect_pc_q <= redirect_pc_d;
      pc_out_q      <= pc_out_d;
      opcode_q      <= opcode_d;
      pf_instr_q    <= pf_instr_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: variable-latency memory model plus an
// architectural program-order model of the instruction stream seen by decode.
module tb_instr_fetch_unit;

  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] OPCode;
  logic [63:0] pc_out;
  logic        instr_valid;
  logic        id_ready;
  logic        BrTaken;
  logic        UncondBr;

  int checks   = 0;
  int failures = 0;

  logic [31:0] memOverride [logic [63:0]];
  logic [63:0] expPc;
  logic        reqActive;
  logic [63:0] reqAddr;
  int          waitCnt;
  int          fixedLat;
  int          stall;

  instr_fetch_unit #(
    .ADDR_WIDTH(64),
    .RESET_PC  (RESET_PC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .OPCode     (OPCode),
    .pc_out     (pc_out),
    .instr_valid(instr_valid),
    .id_ready   (id_ready),
    .BrTaken    (BrTaken),
    .UncondBr   (UncondBr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [63:0] a);
    if (memOverride.exists(a)) return memOverride[a];
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ (a[31:0] >> 5);
  endfunction

  // Architectural branch target using signed integer arithmetic.
  function automatic logic [63:0] targetOf(input logic [63:0] pc, input logic [31:0] op,
                                           input logic unc);
    longint off;
    if (unc) begin
      off = longint'(op[25:0]);
      if (op[25]) off = off - 64'sd67108864;
    end else begin
      off = longint'(op[23:5]);
      if (op[23]) off = off - 64'sd524288;
    end
    return pc + 64'(off * 4);
  endfunction

  task automatic checkEq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    if (instr_valid) begin
      checkEq("pc_out", pc_out, expPc);
      checkEq("opcode", 64'(OPCode), 64'(memWord(expPc)));
    end else begin
      checkEq("req_when_invalid", 64'(imem_req), 64'd1);
    end
  endtask

  // One cycle: check outputs, answer memory, drive decode inputs, advance model.
  task automatic applyStimulus(input bit ready, input bit br, input bit unc);
    bit ack;
    checkOutput();
    ack = 1'b0;
    if (reqActive) checkEq("req_held", 64'(imem_req), 64'd1);
    if (imem_req) begin
      if (!reqActive) begin
        reqActive = 1'b1;
        reqAddr   = imem_addr;
        waitCnt   = (fixedLat >= 0) ? fixedLat : int'($urandom_range(0, 3));
      end else begin
        checkEq("addr_stable", imem_addr, reqAddr);
      end
      if (waitCnt == 0) begin
        ack       = 1'b1;
        reqActive = 1'b0;
      end else begin
        waitCnt--;
      end
    end else begin
      reqActive = 1'b0;
    end
    imem_ack   = ack;
    imem_rdata = ack ? memWord(imem_addr) : $urandom;
    id_ready   = ready;
    BrTaken    = br;
    UncondBr   = unc;
    if (instr_valid && ready) begin
      expPc = br ? targetOf(expPc, memWord(expPc), unc) : expPc + 64'd4;
      stall = 0;
    end else begin
      stall++;
    end
    @(negedge clk);
  endtask

  task automatic doReset(input int n);
    reset    = 1'b1;
    imem_ack = 1'b0;
    id_ready = 1'b0;
    BrTaken  = 1'b0;
    UncondBr = 1'b0;
    #1;
    checkEq("rst_req", 64'(imem_req), 64'd0);
    checkEq("rst_valid", 64'(instr_valid), 64'd0);
    checkEq("rst_pc_out", pc_out, RESET_PC);
    checkEq("rst_opcode", 64'(OPCode), 64'd0);
    checkEq("rst_addr", imem_addr, RESET_PC);
    repeat (n) @(negedge clk);
    reset     = 1'b0;
    reqActive = 1'b0;
    expPc     = RESET_PC;
    stall     = 0;
    #1;
  endtask

  task automatic runTo(input logic [63:0] pc);
    for (int i = 0; i < 60; i++) begin
      if (instr_valid && pc_out == pc) break;
      applyStimulus(1'b1, 1'b0, 1'b0);
    end
    checkEq("reach_pc", pc_out, pc);
  endtask

  initial begin
    memOverride[64'h10] = 32'h17FFFFFE;
    memOverride[64'h20] = 32'hB4000060;
    memOverride[64'h40] = 32'hB4000060;
    imem_rdata = '0;
    fixedLat   = 0;
    reqActive  = 1'b0;
    reqAddr    = '0;
    waitCnt    = 0;
    stall      = 0;
    expPc      = RESET_PC;

    // Sequential streaming with same-cycle ack.
    doReset(2);
    checkEq("t1_addr0", imem_addr, 64'h0);
    checkEq("t1_valid0", 64'(instr_valid), 64'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkEq("t1_valid1", 64'(instr_valid), 64'd1);
    checkEq("t1_pc0", pc_out, 64'h0);
    checkEq("t1_addr4", imem_addr, 64'h4);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkEq("t1_pc4", pc_out, 64'h4);
    checkEq("t1_addr8", imem_addr, 64'h8);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkEq("t1_pc8", pc_out, 64'h8);

    // Unconditional B at 0x10 back to 0x08, prefetch acked same cycle.
    runTo(64'h10);
    checkEq("b_addr14", imem_addr, 64'h14);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkEq("b_bubble", 64'(instr_valid), 64'd0);
    checkEq("b_addr8", imem_addr, 64'h8);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkEq("b_valid", 64'(instr_valid), 64'd1);
    checkEq("b_pc8", pc_out, 64'h8);

    // CBZ at 0x20 to 0x2C with 3-cycle delayed ack of 0x24.
    runTo(64'h20);
    fixedLat = 3;
    checkEq("cbz_addr24", imem_addr, 64'h24);
    applyStimulus(1'b1, 1'b1, 1'b0);
    fixedLat = 0;
    for (int i = 0; i < 3; i++) begin
      checkEq("cbz_drain_valid", 64'(instr_valid), 64'd0);
      checkEq("cbz_drain_addr", imem_addr, 64'h24);
      applyStimulus(1'b1, 1'b0, 1'b0);
    end
    checkEq("cbz_addr2c", imem_addr, 64'h2C);
    checkEq("cbz_valid0", 64'(instr_valid), 64'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkEq("cbz_pc2c", pc_out, 64'h2C);

    // Decode stalled for 5 cycles at pc 0.
    doReset(2);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkEq("stall_pc0", pc_out, 64'h0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkEq("stall_noreq", 64'(imem_req), 64'd0);
      checkEq("stall_hold_pc", pc_out, 64'h0);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    checkEq("stall_noreq_last", 64'(imem_req), 64'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkEq("stall_pc4", pc_out, 64'h4);
    checkEq("stall_req", 64'(imem_req), 64'd1);
    checkEq("stall_addr8", imem_addr, 64'h8);

    // Not-taken conditional falls through.
    runTo(64'h40);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkEq("nt_pc44", pc_out, 64'h44);

    // Reset while draining a stale fetch.
    fixedLat = 5;
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkEq("drain_valid0", 64'(instr_valid), 64'd0);
    checkEq("drain_req", 64'(imem_req), 64'd1);
    checkEq("drain_addr48", imem_addr, 64'h48);
    doReset(2);
    checkEq("post_rst_addr", imem_addr, RESET_PC);
    checkEq("post_rst_req", 64'(imem_req), 64'd1);
    fixedLat = 0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkEq("post_rst_pc", pc_out, RESET_PC);
    checkEq("post_rst_valid", 64'(instr_valid), 64'd1);

    // Randomized traffic against the program-order model.
    fixedLat = -1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) doReset(int'($urandom_range(1, 2)));
      applyStimulus(($urandom_range(0, 9) < 7), ($urandom_range(0, 3) == 0), 1'($urandom));
      if (stall > 60) begin
        checks++;
        failures++;
        $display("[TB] FAIL watchdog: stalled %0d cycles, required at most 60", stall);
        break;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage that sits directly upstream of the CPU control/decode block. It drives the 32-bit instruction on OPCode and the PC of that instruction to decode. Decode returns BrTaken and UncondBr for the instruction it consumes; this block resolves the branch target itself and redirects. It has a single-request instruction-memory handshake with variable latency, one prefetch slot, and discard of stale fetches after a taken branch.

Parameters:
ADDR_WIDTH, 64, width of PC and instruction address
RESET_PC, 64'h0, address of the first fetch after reset

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
imem_req  output  1  request to instruction memory; held until imem_ack
imem_addr  output  ADDR_WIDTH  request address; stable while imem_req=1 and no ack
imem_ack  input  1  memory returns data this cycle (same cycle as req allowed)
imem_rdata  input  32  instruction word, valid when imem_ack=1
OPCode  output  32  instruction presented to decode/control
pc_out  output  ADDR_WIDTH  address of OPCode
instr_valid  output  1  OPCode/pc_out hold a valid instruction
id_ready  input  1  decode accepts; consume = instr_valid & id_ready
BrTaken  input  1  from control; sampled only on consume
UncondBr  input  1  from control; selects imm26 (1) or imm19 (0); sampled only on consume

Behaviour:
- Reset values (held while reset=1): state=FETCH, fetch_pc=RESET_PC, OPCode=32'h0, pc_out=RESET_PC, instr_valid=0, imem_req=0 (gated by reset), prefetch slot empty.
- Registers: head (OPCode, pc_out), pf_instr (prefetched word; its PC is always pc_out+4), fetch_pc, redirect_pc, state.
- Branch target: pc_out + (sign-extend(UncondBr ? OPCode[25:0] : OPCode[23:5]) << 2), modulo 2^ADDR_WIDTH.
- imem_addr = fetch_pc at all times. imem_req=1 in FETCH, PREFETCH and DRAIN; imem_req=0 in BUFFERED.
- instr_valid=1 in PREFETCH and BUFFERED; 0 in FETCH and DRAIN. OPCode/pc_out hold their last value when invalid; the bench does not check them then.
- FETCH: on ack -> head<=imem_rdata, pc_out<=fetch_pc, fetch_pc+=4, go to PREFETCH.
- PREFETCH:
  - consume & BrTaken & ack -> discard rdata, fetch_pc<=target, go to FETCH.
  - consume & BrTaken & !ack -> redirect_pc<=target, go to DRAIN (address held).
  - consume & !BrTaken & ack -> head<=rdata, pc_out<=fetch_pc, fetch_pc+=4, stay in PREFETCH.
  - consume & !BrTaken & !ack -> go to FETCH (request continues unchanged).
  - !consume & ack -> pf_instr<=rdata, fetch_pc+=4, go to BUFFERED.
  - otherwise, hold.
- BUFFERED:
  - consume & BrTaken -> drop pf_instr, fetch_pc<=target, go to FETCH.
  - consume & !BrTaken -> head<=pf_instr, pc_out+=4, go to PREFETCH (fetch_pc already pc_out+8).
- DRAIN: on ack -> discard rdata, fetch_pc<=redirect_pc, go to FETCH. Never exposes drained data.
- Latency: with same-cycle ack and id_ready=1, first instr_valid is 1 cycle after reset release. Steady state is 1 instruction/cycle sequentially. A taken branch costs 1 bubble (or drain latency + 1).
- fetch_pc and pc_out wrap modulo 2^ADDR_WIDTH. Reset mid-request abandons the request; memory must tolerate a dropped req.

Decomposition:
- Package fetch_pkg: enum fetch_state_t {FETCH, PREFETCH, BUFFERED, DRAIN}; INSTR_WIDTH=32; field constants IMM26_MSB=25, IMM19_MSB=23, IMM19_LSB=5.
- Sub-module fetch_br_target: combinational sign-extend/shift/add producing the branch target from pc_out, OPCode and UncondBr.

Test Plan:
- Reset release, ack same cycle as req, id_ready=1, no branches: imem_addr 0,4,8,...; pc_out 0,4,8 on consecutive cycles with instr_valid=1 from cycle 1.
- B at pc 0x10 (imm26=-2), BrTaken=1, UncondBr=1, prefetch of 0x14 acked same cycle: 0x14 is never presented; next valid pc_out=0x08 after 1 bubble.
- CBZ at pc 0x20 (imm19=+3), BrTaken=1, UncondBr=0, ack delayed 3 cycles: imem_addr stays 0x24 until ack, instr_valid=0 throughout, then imem_addr=0x2C, next pc_out=0x2C.
- id_ready=0 for 5 cycles at pc 0: after ack of 0x4, imem_req=0 and pc_out stays 0; raising id_ready gives pc_out=4 next cycle with no new request, then imem_addr=0x8.
- BrTaken=0 conditional at pc 0x40: falls through, pc_out=0x44 next cycle.
- reset asserted in DRAIN: outputs take reset values immediately; after release, first imem_addr=RESET_PC and the late ack is ignored by the bench memory.
